// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with private HI/LO registers.
// Define ALU_MULDIV_ACC_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module alu_muldiv #(
   parameter int W        = 32,
   parameter int MUL_FAST = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         flush,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         busy,
   output logic         stall,
   output logic         done,
   output logic         div_zero
);
   localparam int            CW       = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef ALU_MULDIV_ACC_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_div_q, is_div_d;
   logic          neg_q, neg_d;
   logic          rneg_q, rneg_d;
   logic          dz_q, dz_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  bmag_q, bmag_d;
   logic [W-1:0]  wh_q, wh_d;
   logic [W-1:0]  wl_q, wl_d;
   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic          div_zero_q, div_zero_d;
`ifdef ALU_MULDIV_ACC_EN
   logic          acc_q, acc_d;
   logic          sub_q, sub_d;
   logic          dec_acc, dec_sub;
`endif

   logic         dec_md, dec_signed, dec_div;
   logic         accept, last;
   logic [W-1:0] a_mag, b_mag;

   always_comb begin
      dec_md     = 1'b0;
      dec_signed = 1'b0;
      dec_div    = 1'b0;
`ifdef ALU_MULDIV_ACC_EN
      dec_acc    = 1'b0;
      dec_sub    = 1'b0;
`endif
      case (op)
         OP_MULT:  begin dec_md = 1'b1; dec_signed = 1'b1; end
         OP_MULTU: dec_md = 1'b1;
         OP_DIV:   begin dec_md = 1'b1; dec_signed = 1'b1; dec_div = 1'b1; end
         OP_DIVU:  begin dec_md = 1'b1; dec_div = 1'b1; end
`ifdef ALU_MULDIV_ACC_EN
         OP_MADD:  begin dec_md = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; end
         OP_MADDU: begin dec_md = 1'b1; dec_acc = 1'b1; end
         OP_MSUB:  begin dec_md = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
         OP_MSUBU: begin dec_md = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
`endif
         default: ;
      endcase
   end

   assign accept = start && !flush && dec_md && (state_q == ST_IDLE || state_q == ST_DONE);
   assign a_mag  = (dec_signed && a[W-1]) ? -a : a;
   assign b_mag  = (dec_signed && b[W-1]) ? -b : b;

   // One shift-add multiply step and one restoring divide step on the work pair.
   logic [W:0]   mul_sum, div_trial;
   logic [W-1:0] mul_h, mul_l, div_h, div_l;
   logic         div_ge;

   always_comb begin
      mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, bmag_q} : '0);
      mul_h     = mul_sum[W:1];
      mul_l     = {mul_sum[0], wl_q[W-1:1]};
      div_trial = {wh_q, wl_q[W-1]} - {1'b0, bmag_q};
      div_ge    = ~div_trial[W];
      div_h     = div_ge ? div_trial[W-1:0] : {wh_q[W-2:0], wl_q[W-1]};
      div_l     = {wl_q[W-2:0], div_ge};
   end

   logic [2*W-1:0] mul_mag;
   logic           mul_last;

   generate
      if (MUL_FAST != 0) begin : g_mul_fast
         assign mul_mag  = {{W{1'b0}}, wl_q} * {{W{1'b0}}, bmag_q};
         assign mul_last = 1'b1;
      end else begin : g_mul_iter
         assign mul_mag  = {mul_h, mul_l};
         assign mul_last = (cnt_q == LAST_CNT);
      end
   endgenerate

   assign last = is_div_q ? (cnt_q == LAST_CNT) : mul_last;

   // Sign fixups are applied to the final step's output, so they cost no extra cycle.
   logic [2*W-1:0] mul_res, prod_res;
   logic [W-1:0]   quo_res, rem_res;

   always_comb begin
      mul_res = neg_q ? -mul_mag : mul_mag;
`ifdef ALU_MULDIV_ACC_EN
      if (!acc_q)
         prod_res = mul_res;
      else if (sub_q)
         prod_res = {hi_q, lo_q} - mul_res;
      else
         prod_res = {hi_q, lo_q} + mul_res;
`else
      prod_res = mul_res;
`endif
      if (dz_q) begin
         quo_res = '1;
         rem_res = a_q;
      end else begin
         quo_res = neg_q ? -div_l : div_l;
         rem_res = rneg_q ? -div_h : div_h;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      dz_d       = dz_q;
      a_d        = a_q;
      bmag_d     = bmag_q;
      wh_d       = wh_q;
      wl_d       = wl_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
`ifdef ALU_MULDIV_ACC_EN
      acc_d      = acc_q;
      sub_d      = sub_q;
`endif
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               state_d = ST_IDLE;
               if (accept) begin
                  state_d  = ST_BUSY;
                  cnt_d    = '0;
                  is_div_d = dec_div;
                  neg_d    = dec_signed && (a[W-1] ^ b[W-1]);
                  rneg_d   = dec_signed && a[W-1];
                  dz_d     = dec_div && (b == '0);
                  a_d      = a;
                  bmag_d   = b_mag;
                  wh_d     = '0;
                  wl_d     = a_mag;
`ifdef ALU_MULDIV_ACC_EN
                  acc_d    = dec_acc;
                  sub_d    = dec_sub;
`endif
               end else if (start && op == OP_MTHI) begin
                  hi_d = a;
               end else if (start && op == OP_MTLO) begin
                  lo_d = a;
               end
            end
            ST_BUSY: begin
               if (last) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
                  if (is_div_q) begin
                     hi_d       = rem_res;
                     lo_d       = quo_res;
                     div_zero_d = dz_q;
                  end else begin
                     {hi_d, lo_d} = prod_res;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (is_div_q) begin
                     wh_d = div_h;
                     wl_d = div_l;
                  end else begin
                     wh_d = mul_h;
                     wl_d = mul_l;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         dz_q       <= 1'b0;
         a_q        <= '0;
         bmag_q     <= '0;
         wh_q       <= '0;
         wl_q       <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
`ifdef ALU_MULDIV_ACC_EN
         acc_q      <= 1'b0;
         sub_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         dz_q       <= dz_d;
         a_q        <= a_d;
         bmag_q     <= bmag_d;
         wh_q       <= wh_d;
         wl_q       <= wl_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
`ifdef ALU_MULDIV_ACC_EN
         acc_q      <= acc_d;
         sub_q      <= sub_d;
`endif
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q == ST_BUSY);
   assign done     = (state_q == ST_DONE);
   assign div_zero = div_zero_q;
   assign stall    = busy || (start && dec_md && state_q == ST_IDLE && !flush);

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors against a transaction-level arithmetic model of alu_muldiv.
// Define ALU_MULDIV_ACC_EN to exercise the accumulate ops instead of their NOP behaviour.
module tb_alu_muldiv;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         flush;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         stall;
   logic         done;
   logic         div_zero;

   always #5 clk = ~clk;

   alu_muldiv #(.W(W), .MUL_FAST(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .stall    (stall),
      .done     (done),
      .div_zero (div_zero)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic bit is_md(logic [3:0] o);
      if (o >= 4'd1 && o <= 4'd4) return 1'b1;
`ifdef ALU_MULDIV_ACC_EN
      if (o >= 4'd7 && o <= 4'd10) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Model: an accepted op occupies W busy cycles, then its result lands in HI/LO.
   int           m_rem = 0;
   bit           m_done = 1'b0;
   bit           m_dz = 1'b0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [63:0]  p_res;
   bit           p_div, p_dz;
   int           p_acc;
   longint       sa, sb, sq, sr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_rem = 0;
         end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               case (p_acc)
                  1:       {m_hi, m_lo} = {m_hi, m_lo} + p_res;
                  2:       {m_hi, m_lo} = {m_hi, m_lo} - p_res;
                  default: {m_hi, m_lo} = p_res;
               endcase
               if (p_div) m_dz = p_dz;
               m_done = 1'b1;
            end
         end else if (start) begin
            if (is_md(op)) begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
               p_div = (op == 4'd3 || op == 4'd4);
               p_dz  = p_div && (b == '0);
               p_acc = (op == 4'd7 || op == 4'd8) ? 1 : (op == 4'd9 || op == 4'd10) ? 2 : 0;
               case (op)
                  4'd1, 4'd7, 4'd9: p_res = sa * sb;
                  4'd2, 4'd8, 4'd10: p_res = {32'h0, a} * {32'h0, b};
                  default: begin
                     if (b == '0) begin
                        p_res = {a, 32'hFFFF_FFFF};
                     end else if (op == 4'd3) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        p_res = {sr[31:0], sq[31:0]};
                     end else begin
                        p_res = {a % b, a / b};
                     end
                  end
               endcase
               m_rem = W;
            end else if (op == 4'd5) begin
               m_hi = a;
            end else if (op == 4'd6) begin
               m_lo = a;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("busy", busy, m_rem > 0);
         chk("done", done, m_done);
         chk("stall", stall, (m_rem > 0) || (start && is_md(op) && !flush && m_rem == 0 && !m_done));
         if (m_done) chk("div_zero", div_zero, m_dz);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input int exp_k);
      int k = 0;
      int nb = 0;
      while (!done && k < 200) begin
         if (busy) nb++;
         tick();
         k++;
      end
      chk("latency", 64'(k), 64'(exp_k));
      chk("busy_cycles", 64'(nb), 64'(exp_k));
   endtask

   task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] eh, input logic [W-1:0] el);
      issue(o, x, y);
      wait_done(W);
      chk("hi_lit", hi, eh);
      chk("lo_lit", lo, el);
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h div_zero=%0b", o, x, y, hi, lo, div_zero);
   endtask

   task automatic single(input logic [3:0] o, input logic [W-1:0] x);
      start = 1'b1; op = o; a = x; b = '0;
      tick();
      start = 1'b0; op = 4'd0;
      $display("op=%0d a=%h -> hi=%h lo=%h", o, x, hi, lo);
   endtask

   initial begin
      int ndone;
      rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0;
      repeat (2) tick();
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_stall", stall, 0);
      rst = 1'b0;
      tick();

      run(4'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run(4'd4, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
      chk("dz_set", div_zero, 1);
      run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      chk("dz_clear", div_zero, 0);
      run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run(4'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E);
      run(4'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      tick();
      run(4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
      tick();

      // Abort a divide mid-iteration: HI/LO keep the previous result, no done ever.
      issue(4'd4, 32'd200, 32'd3);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_hi", hi, 32'd2);
      chk("flush_lo", lo, 32'd14);
      ndone = 0;
      repeat (40) begin
         if (done) ndone++;
         tick();
      end
      chk("flush_no_done", 64'(ndone), 0);
      $display("op=4 a=000000c8 b=00000003 flushed -> hi=%h lo=%h", hi, lo);

      // Flush landing on the commit edge suppresses the write.
      issue(4'd2, 32'd5, 32'd5);
      repeat (W - 1) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("lastflush_done", done, 0);
      chk("lastflush_hi", hi, 32'd2);
      chk("lastflush_lo", lo, 32'd14);
      $display("op=2 a=00000005 b=00000005 flushed at commit -> hi=%h lo=%h", hi, lo);

      single(4'd5, 32'h0000_1234);
      chk("mthi", hi, 32'h0000_1234);
      start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4; flush = 1'b1;
      chk("flush_start_stall", stall, 0);
      tick();
      start = 1'b0; op = 4'd0; flush = 1'b0;
      chk("flush_start_busy", busy, 0);
      chk("flush_start_hi", hi, 32'h0000_1234);
      $display("op=1 a=00000003 b=00000004 with flush -> busy=%0b hi=%h", busy, hi);
      single(4'd6, 32'h0000_5678);
      chk("mtlo", lo, 32'h0000_5678);

      start = 1'b1; op = 4'd15; a = 32'd9; b = 32'd9;
      chk("undef_stall", stall, 0);
      tick();
      start = 1'b0; op = 4'd0;
      chk("undef_busy", busy, 0);
      chk("undef_lo", lo, 32'h0000_5678);
      $display("op=15 a=00000009 b=00000009 -> hi=%h lo=%h", hi, lo);

`ifdef ALU_MULDIV_ACC_EN
      single(4'd5, 32'd0);
      single(4'd6, 32'd5);
      run(4'd7, 32'd2, 32'd3, 32'd0, 32'd11);
      run(4'd10, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
      tick();
`else
      start = 1'b1; op = 4'd7; a = 32'd2; b = 32'd3;
      chk("madd_nop_stall", stall, 0);
      tick();
      start = 1'b0; op = 4'd0;
      chk("madd_nop_busy", busy, 0);
      chk("madd_nop_hi", hi, 32'h0000_1234);
      chk("madd_nop_lo", lo, 32'h0000_5678);
      $display("op=7 a=00000002 b=00000003 -> hi=%h lo=%h", hi, lo);
`endif

      // Asynchronous reset in the middle of a divide clears everything at once.
      issue(4'd3, 32'd1000, 32'd7);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      $display("rst during op=3 -> hi=%h lo=%h busy=%0b", hi, lo, busy);
      tick();
      rst = 1'b0;
      tick();
      run(4'd2, 32'd6, 32'd7, 32'd0, 32'd42);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
